// File: rtl/pix_pattern_controller.sv
// Pixel output stage: turns source pixels plus timing counters into registered RGB drive,
// with pass-through, colour-bar, solid-colour and white-border modes switched only at frame start.
module pix_pattern_controller #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int CNT_W    = 10,
  parameter int R_W      = 3,
  parameter int G_W      = 3,
  parameter int B_W      = 2,
  parameter int BORDER_W = 4
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     PixEn,
  input  logic [CNT_W-1:0]         Hcounter,
  input  logic [CNT_W-1:0]         Vcounter,
  input  logic [R_W+G_W+B_W-1:0]   PixData,
  input  logic [1:0]               Mode,
  input  logic [R_W+G_W+B_W-1:0]   SolidColor,
  output logic [R_W-1:0]           Red,
  output logic [G_W-1:0]           Green,
  output logic [B_W-1:0]           Blue,
  output logic                     Active,
  output logic                     FrameStart,
  output logic [1:0]               ModeCur
);

  localparam int PIX_W    = R_W + G_W + B_W;
  localparam int STRIPE_W = H_ACTIVE / 8;
  localparam int PC_W     = (STRIPE_W > 1) ? $clog2(STRIPE_W) : 1;

  localparam logic [CNT_W-1:0] LP_H_ACT = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_V_ACT = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_BW    = CNT_W'(BORDER_W);
  localparam logic [CNT_W-1:0] LP_H_BHI = CNT_W'(H_ACTIVE - BORDER_W);
  localparam logic [CNT_W-1:0] LP_V_BHI = CNT_W'(V_ACTIVE - BORDER_W);
  localparam logic [PC_W-1:0]  LP_PC_LAST = PC_W'(STRIPE_W - 1);

  // Bar colours as {R,G,B} on/off flags, left to right.
  function automatic logic [PIX_W-1:0] bar_color(input logic [2:0] idx);
    logic [2:0] m;
    case (idx)
      3'd0:    m = 3'b111;
      3'd1:    m = 3'b110;
      3'd2:    m = 3'b011;
      3'd3:    m = 3'b010;
      3'd4:    m = 3'b101;
      3'd5:    m = 3'b100;
      3'd6:    m = 3'b001;
      default: m = 3'b000;
    endcase
    return {{R_W{m[2]}}, {G_W{m[1]}}, {B_W{m[0]}}};
  endfunction

  logic [R_W-1:0]   r_red;
  logic [G_W-1:0]   r_green;
  logic [B_W-1:0]   r_blue;
  logic             r_active;
  logic             r_frame_start;
  logic [1:0]       r_mode;
  logic [PIX_W-1:0] r_solid;
  logic [PC_W-1:0]  r_pixcnt;
  logic [2:0]       r_stripe;

  logic             w_frame_start;
  logic             w_h_vis;
  logic             w_visible;
  logic             w_border;
  logic [1:0]       w_mode;
  logic [PIX_W-1:0] w_solid;
  logic [PC_W-1:0]  w_pixcnt_nxt;
  logic [2:0]       w_stripe_nxt;
  logic [PIX_W-1:0] w_pix;

  assign w_frame_start = PixEn && (Hcounter == '0) && (Vcounter == '0);
  assign w_h_vis       = Hcounter < LP_H_ACT;
  assign w_visible     = w_h_vis && (Vcounter < LP_V_ACT);
  assign w_border      = (Hcounter < LP_BW) || (Hcounter >= LP_H_BHI) ||
                         (Vcounter < LP_BW) || (Vcounter >= LP_V_BHI);

  // The frame-start pixel already uses the newly requested mode and colour.
  assign w_mode  = w_frame_start ? Mode : r_mode;
  assign w_solid = w_frame_start ? SolidColor : r_solid;

  // Counters hold the stripe position of the current pixel; the next value
  // is also the position used for colouring this pixel.
  always_comb begin
    w_pixcnt_nxt = r_pixcnt;
    w_stripe_nxt = r_stripe;
    if (Hcounter == '0) begin
      w_pixcnt_nxt = '0;
      w_stripe_nxt = '0;
    end else if (w_h_vis) begin
      if (r_pixcnt == LP_PC_LAST) begin
        w_pixcnt_nxt = '0;
        if (r_stripe != 3'd7) w_stripe_nxt = r_stripe + 3'd1;
      end else begin
        w_pixcnt_nxt = r_pixcnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_pix = '0;
    if (w_visible) begin
      case (w_mode)
        2'd0:    w_pix = PixData;
        2'd1:    w_pix = bar_color(w_stripe_nxt);
        2'd2:    w_pix = w_solid;
        default: w_pix = w_border ? '1 : PixData;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
      r_active      <= 1'b0;
      r_frame_start <= 1'b0;
      r_mode        <= 2'd0;
      r_solid       <= '0;
      r_pixcnt      <= '0;
      r_stripe      <= '0;
    end else begin
      r_frame_start <= w_frame_start;
      if (PixEn) begin
        r_red    <= w_pix[PIX_W-1 -: R_W];
        r_green  <= w_pix[B_W +: G_W];
        r_blue   <= w_pix[B_W-1:0];
        r_active <= w_visible;
        r_pixcnt <= w_pixcnt_nxt;
        r_stripe <= w_stripe_nxt;
        if (w_frame_start) begin
          r_mode  <= Mode;
          r_solid <= SolidColor;
        end
      end
    end
  end

  assign Red        = r_red;
  assign Green      = r_green;
  assign Blue       = r_blue;
  assign Active     = r_active;
  assign FrameStart = r_frame_start;
  assign ModeCur    = r_mode;

endmodule

// File: tb/tb_pix_pattern_controller.sv
// Directed bench for pix_pattern_controller at default 640x480 RGB332 parameters.
module tb_pix_pattern_controller;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       PixEn;
  logic [9:0] Hcounter;
  logic [9:0] Vcounter;
  logic [7:0] PixData;
  logic [1:0] Mode;
  logic [7:0] SolidColor;
  logic [2:0] Red;
  logic [2:0] Green;
  logic [1:0] Blue;
  logic       Active;
  logic       FrameStart;
  logic [1:0] ModeCur;

  int n_vec = 0;
  int n_err = 0;

  pix_pattern_controller dut (
    .Clk(Clk), .Rst_n(Rst_n), .PixEn(PixEn), .Hcounter(Hcounter), .Vcounter(Vcounter),
    .PixData(PixData), .Mode(Mode), .SolidColor(SolidColor), .Red(Red), .Green(Green),
    .Blue(Blue), .Active(Active), .FrameStart(FrameStart), .ModeCur(ModeCur)
  );

  always #5 Clk = ~Clk;

  wire [7:0] rgb = {Red, Green, Blue};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and sample just after the capturing edge.
  task automatic px(input int h, input int v, input logic [7:0] d, input logic en);
    Hcounter = 10'(h);
    Vcounter = 10'(v);
    PixData  = d;
    PixEn    = en;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [7:0] bar_exp(input int h);
    logic [7:0] tbl [8];
    tbl = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
    if (h >= 640) return 8'h00;
    return tbl[h / 80];
  endfunction

  initial begin
    logic [7:0] prev;
    Rst_n = 1'b0; PixEn = 1'b0; Hcounter = '0; Vcounter = '0;
    PixData = '0; Mode = 2'd0; SolidColor = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_rgb", rgb, 8'h00);
    chk("rst_active", Active, 1'b0);
    chk("rst_fs", FrameStart, 1'b0);
    chk("rst_mode", ModeCur, 2'd0);
    Rst_n = 1'b1;

    // Pass-through
    px(5, 5, 8'hE0, 1'b1);
    chk("pass_red", Red, 3'b111);
    chk("pass_green", Green, 3'b000);
    chk("pass_blue", Blue, 2'b00);
    chk("pass_active", Active, 1'b1);
    px(640, 5, 8'hE0, 1'b1);
    chk("hblank_rgb", rgb, 8'h00);
    chk("hblank_active", Active, 1'b0);
    px(5, 480, 8'hFF, 1'b1);
    chk("vblank_rgb", rgb, 8'h00);
    chk("vblank_active", Active, 1'b0);

    // Colour bars over one full line
    Mode = 2'd1;
    for (int h = 0; h < 800; h++) begin
      px(h, 0, 8'h5A, 1'b1);
      chk("bars_rgb", rgb, bar_exp(h));
      chk("bars_active", Active, (h < 640));
      if (h == 0) begin
        chk("bars_fs", FrameStart, 1'b1);
        chk("bars_mode", ModeCur, 2'd1);
      end
      if (h == 1) chk("bars_fs_drop", FrameStart, 1'b0);
    end
    // Second line: counters resync at H=0
    for (int h = 0; h < 170; h++) begin
      px(h, 1, 8'h5A, 1'b1);
      if (h == 0 || h == 79 || h == 80 || h == 160 || h == 169) chk("bars_l1", rgb, bar_exp(h));
    end

    // Mode request mid-frame waits for the frame start
    Mode = 2'd0;
    px(0, 0, 8'hE0, 1'b1);
    chk("sw_m0", ModeCur, 2'd0);
    chk("sw_m0_rgb", rgb, 8'hE0);
    Mode = 2'd2; SolidColor = 8'h03;
    px(100, 10, 8'hE0, 1'b1);
    chk("sw_hold_rgb", rgb, 8'hE0);
    chk("sw_hold_mode", ModeCur, 2'd0);
    chk("sw_hold_fs", FrameStart, 1'b0);
    px(200, 10, 8'h1C, 1'b1);
    chk("sw_hold_rgb2", rgb, 8'h1C);
    px(0, 0, 8'hE0, 1'b1);
    chk("sw_fs", FrameStart, 1'b1);
    chk("sw_blue", Blue, 2'b11);
    chk("sw_red", Red, 3'b000);
    chk("sw_mode", ModeCur, 2'd2);
    SolidColor = 8'hFF;
    px(1, 0, 8'hE0, 1'b1);
    chk("sw_fs_once", FrameStart, 1'b0);
    chk("sw_solid_held", rgb, 8'h03);
    px(300, 300, 8'hE0, 1'b1);
    chk("sw_solid_mid", rgb, 8'h03);

    // Border mode
    Mode = 2'd3;
    px(0, 0, 8'h00, 1'b1);
    chk("bd_mode", ModeCur, 2'd3);
    chk("bd_h0v0", rgb, 8'hFF);
    px(0, 4, 8'h00, 1'b1);   chk("bd_h0", rgb, 8'hFF);
    px(3, 4, 8'h00, 1'b1);   chk("bd_h3", rgb, 8'hFF);
    px(4, 4, 8'h00, 1'b1);   chk("bd_h4v4", rgb, 8'h00);
    px(635, 4, 8'h00, 1'b1); chk("bd_h635", rgb, 8'h00);
    px(636, 4, 8'h00, 1'b1); chk("bd_h636", rgb, 8'hFF);
    px(639, 4, 8'h00, 1'b1); chk("bd_h639", rgb, 8'hFF);
    px(300, 3, 8'h00, 1'b1); chk("bd_v3", rgb, 8'hFF);
    px(300, 475, 8'h00, 1'b1); chk("bd_v475", rgb, 8'h00);
    px(300, 476, 8'h00, 1'b1); chk("bd_v476", rgb, 8'hFF);
    px(5, 479, 8'h00, 1'b1); chk("bd_v479", rgb, 8'hFF);
    px(100, 100, 8'h5A, 1'b1); chk("bd_inner", rgb, 8'h5A);
    px(5, 480, 8'h00, 1'b1);
    chk("bd_vblank", rgb, 8'h00);
    chk("bd_vblank_act", Active, 1'b0);

    // Bars with PixEn 1-of-4; idle cycles present tempting counter values
    Mode = 2'd1;
    prev = rgb;
    for (int h = 0; h < 640; h++) begin
      px(h, 0, 8'h5A, 1'b1);
      chk("en_rgb", rgb, bar_exp(h));
      if (h == 0) chk("en_fs", FrameStart, 1'b1);
      prev = bar_exp(h);
      for (int k = 0; k < 3; k++) begin
        px(0, 7, 8'hE0, 1'b0);
        chk("en_fs_idle", FrameStart, 1'b0);
      end
      chk("en_hold", rgb, prev);
    end
    Mode = 2'd0;
    px(0, 0, 8'hE0, 1'b0);
    chk("en_nolatch_mode", ModeCur, 2'd1);
    chk("en_nolatch_fs", FrameStart, 1'b0);

    // Asynchronous reset mid-line in bar mode
    Mode = 2'd1;
    for (int h = 0; h <= 100; h++) px(h, 0, 8'h00, 1'b1);
    chk("ar_pre", rgb, 8'hFC);
    #2 Rst_n = 1'b0;
    #1;
    chk("ar_rgb", rgb, 8'h00);
    chk("ar_active", Active, 1'b0);
    chk("ar_mode", ModeCur, 2'd0);
    #1 Rst_n = 1'b1;
    px(5, 5, 8'hE0, 1'b1);
    chk("ar_pass_rgb", rgb, 8'hE0);
    chk("ar_pass_mode", ModeCur, 2'd0);
    px(0, 0, 8'h00, 1'b1);
    chk("ar_relatch_mode", ModeCur, 2'd1);
    chk("ar_relatch_rgb", rgb, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
